// File: rtl/regfile_pkg.sv
// Purpose: shared constants and FSM state type for the integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

    // Bus geometry of the integer register file.
    localparam int REG_BUS_W    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

    // Reset is active-low.
    localparam logic RST_ENABLE = 1'b0;

    // RESET is never stored: it is the effective state whenever rst is low.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } init_state_e;

endpackage

// File: rtl/regfile_init_seq.sv
// Purpose: post-reset zero sweep sequencer (RESET/INIT/READY) for the register file.
// Latency: sweep writes $1..$(NUM_REGS-1) on consecutive edges after reset release.
// Backpressure: init_busy_o stays high through reset and the sweep; pipeline stalls on it.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   sweep_we        write-enable for the zero sweep (this cycle's edge)
//   sweep_addr      register being cleared on this cycle's edge
//   init_busy_o     high in RESET and INIT, low only in READY
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              init_busy_o
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    init_state_e       state_q, state_d, state_cur;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_INIT;
            cnt_q   <= FIRST_ADDR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_cur   = (rst == RST_ENABLE) ? ST_RESET : state_q;
        state_d     = state_cur;
        cnt_d       = cnt_q;
        sweep_we    = 1'b0;
        sweep_addr  = cnt_q;
        init_busy_o = 1'b1;
        case (state_cur)
            ST_RESET: begin
                state_d = ST_INIT;
                cnt_d   = FIRST_ADDR;
            end
            ST_INIT: begin
                sweep_we = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                // The edge that clears the last register ends the sweep.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                init_busy_o = 1'b0;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = FIRST_ADDR;
            end
        endcase
    end

endmodule

// File: rtl/regfile.sv
// Purpose: 2-read/1-write integer register file, $0 hardwired to zero, zero sweep after reset.
// Latency: reads combinational (0 cycles); writes visible one edge after commit.
// Backpressure: init_busy_o holds decode/fetch off until the post-reset sweep finishes.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   we, waddr, wdata            write-back port (dropped unless READY; $0 discarded)
//   re1, raddr1 -> rdata1       decode $rs read port
//   re2, raddr2 -> rdata2       decode $rt read port
//   init_busy_o                 sweep in progress
// Config macro: REGFILE_BYPASS_EN -- when defined, a same-cycle write to the read
// address is forwarded to the read port (write-first); otherwise the old value is read.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM    // must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy_o
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              ready;
    logic              wr_commit;

    regfile_init_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .sweep_we    (sweep_we),
        .sweep_addr  (sweep_addr),
        .init_busy_o (init_busy_o)
    );

    assign ready     = (rst != RST_ENABLE) && !init_busy_o;
    assign wr_commit = ready && (we == WRITE_ENABLE) && (waddr != '0);

    // No array reset: contents survive a reset until the sweep reaches them.
    // Entry 0 is never written; the read muxes never look at it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            regs[sweep_addr] <= '0;
        end else if (wr_commit) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst != RST_ENABLE && re1 == READ_ENABLE && raddr1 != '0 && ready) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && waddr == raddr1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
`else
            rdata1 = regs[raddr1];
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst != RST_ENABLE && re2 == READ_ENABLE && raddr2 != '0 && ready) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && waddr == raddr2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
`else
            rdata2 = regs[raddr2];
`endif
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Purpose: directed self-checking bench for regfile.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 4ns after it.
// Backpressure: waits on init_busy_o are bounded by a cycle budget.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        init_busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .init_busy_o (init_busy_o)
    );

    task automatic drive_idle();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0;
        re2 = 1'b0; raddr2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at a sample point; counts cycles with init_busy_o high (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (init_busy_o === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #4;
        end
    endtask

    task automatic test_reset();
        int n;
        drive_idle();
        rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd1;
        re2 = 1'b1; raddr2 = 5'd31;
        repeat (3) begin
            @(posedge clk);
            #4;
            tests++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                fails++;
                $display("FAIL reset_rdata: got %h/%h expected 0/0", rdata1, rdata2);
            end
            tests++;
            if (init_busy_o !== 1'b1) begin
                fails++;
                $display("FAIL reset_busy: got %b expected 1", init_busy_o);
            end
        end
        next_cycle();
        rst = 1'b1;
        re1 = 1'b0; re2 = 1'b0;
        #3;
        wait_ready(n);
        tests++;
        if (n != 31) begin
            fails++;
            $display("FAIL init_busy_cycles: got %0d expected 31", n);
        end
    endtask

    task automatic test_sweep_zero();
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            re1 = 1'b1; raddr1 = 5'(i);
            re2 = 1'b1; raddr2 = 5'(i);
            #3;
            tests++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                fails++;
                $display("FAIL sweep_zero r%0d: got %h/%h expected 0/0", i, rdata1, rdata2);
            end
        end
    endtask

    task automatic test_basic();
        next_cycle();
        drive_idle();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        next_cycle();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd5;
        #3;
        tests++;
        if (rdata1 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_rd1: got %h expected 12345678", rdata1);
        end
        tests++;
        if (rdata2 !== 32'h1234_5678) begin
            fails++;
            $display("FAIL basic_rd2_same_addr: got %h expected 12345678", rdata2);
        end
        next_cycle();
        re1 = 1'b0;
        #3;
        tests++;
        if (rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL basic_re_off: got %h expected 0", rdata1);
        end
        // Last register boundary.
        next_cycle();
        we = 1'b1; waddr = 5'd31; wdata = 32'hCAFE_0031;
        re2 = 1'b0;
        next_cycle();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd31;
        #3;
        tests++;
        if (rdata1 !== 32'hCAFE_0031) begin
            fails++;
            $display("FAIL basic_r31: got %h expected cafe0031", rdata1);
        end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        drive_idle();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0;
        re2 = 1'b1; raddr2 = 5'd0;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_same_cycle: got %h/%h expected 0/0", rdata1, rdata2);
        end
        next_cycle();
        we = 1'b0;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            fails++;
            $display("FAIL zero_after: got %h/%h expected 0/0", rdata1, rdata2);
        end
    endtask

    task automatic test_hazard();
        logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h5555_5555;
`else
        exp_same = 32'hAAAA_AAAA;
`endif
        next_cycle();
        drive_idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_AAAA;
        next_cycle();
        wdata = 32'h5555_5555;
        re2 = 1'b1; raddr2 = 5'd7;
        re1 = 1'b0; raddr1 = 5'd7;
        #3;
        tests++;
        if (rdata2 !== exp_same) begin
            fails++;
            $display("FAIL hazard_same_cycle: got %h expected %h", rdata2, exp_same);
        end
        tests++;
        if (rdata1 !== 32'h0) begin
            fails++;
            $display("FAIL hazard_re_off: got %h expected 0", rdata1);
        end
        next_cycle();
        we = 1'b0;
        #3;
        tests++;
        if (rdata2 !== 32'h5555_5555) begin
            fails++;
            $display("FAIL hazard_next_cycle: got %h expected 55555555", rdata2);
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        // Reset from READY: reads gated to 0 while rst is low.
        next_cycle();
        drive_idle();
        rst = 1'b0;
        re1 = 1'b1; raddr1 = 5'd7;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || init_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL ready_reset: got rdata %h busy %b expected 0 1", rdata1, init_busy_o);
        end
        next_cycle();
        rst = 1'b1;
        re1 = 1'b0;
        // Nine edges clear $1..$9, leaving the sweep counter at 10.
        repeat (9) next_cycle();
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd5;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || init_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL init_read_gated: got %h/%h busy %b expected 0/0 1", rdata1, rdata2, init_busy_o);
        end
        next_cycle();
        rst = 1'b0;
        #3;
        tests++;
        if (init_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_init_reset_busy: got %b expected 1", init_busy_o);
        end
        next_cycle();
        rst = 1'b1;
        re1 = 1'b0; re2 = 1'b0;
        #3;
        wait_ready(n);
        tests++;
        if (n != 31) begin
            fails++;
            $display("FAIL mid_init_busy_cycles: got %0d expected 31", n);
        end
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd31;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            fails++;
            $display("FAIL mid_init_swept: got %h/%h expected 0/0", rdata1, rdata2);
        end
    endtask

    task automatic test_init_write_drop();
        int n;
        next_cycle();
        drive_idle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF;
        repeat (20) next_cycle();
        we = 1'b0;
        #3;
        wait_ready(n);
        tests++;
        if (n != 11) begin
            fails++;
            $display("FAIL drop_busy_remaining: got %0d expected 11", n);
        end
        next_cycle();
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd3;
        #3;
        tests++;
        if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
            fails++;
            $display("FAIL init_write_dropped: got %h/%h expected 0/0", rdata1, rdata2);
        end
    endtask

    initial begin
        test_reset();
        test_sweep_zero();
        test_basic();
        test_zero_reg();
        test_hazard();
        test_reset_mid_init();
        test_init_write_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
